aeses_uart_ctrl: RTL and testbench

//  Byte-stream framer between the UART RX/TX pair and the AESES core inside fpga_top.

---
 rtl/aeses_uart_ctrl.sv | 153 +++++++++++++++
 tb/tb_aeses_uart_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aeses_uart_ctrl.sv
// aeses_uart_ctrl: frames the UART byte stream into an AES key and data
// blocks, starts the core on each block and streams the result back to TX.
// Ports: clk/rst (sync, active-high); rx_data/rx_valid byte input;
//   tx_data/tx_valid/tx_ready byte output handshake; aes_key/key_valid,
//   aes_din/aes_start, aes_dout/aes_done core interface; overrun sticky
//   error flag; state_o current FSM state for status LEDs.
module aeses_uart_ctrl #(
  parameter int KEY_BYTES = 32,
  parameter int BLK_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [8*KEY_BYTES-1:0] aes_key,
  output logic                   key_valid,
  output logic [8*BLK_BYTES-1:0] aes_din,
  output logic                   aes_start,
  input  logic [8*BLK_BYTES-1:0] aes_dout,
  input  logic                   aes_done,
  output logic                   overrun,
  output logic [2:0]             state_o
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int BW = 8 * BLK_BYTES;
  localparam int CW = $clog2(KEY_BYTES + 1);

  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLK_BYTES - 1);

  typedef enum logic [2:0] {
    KEY_LOAD = 3'd0,
    BLK_LOAD = 3'd1,
    START    = 3'd2,
    WAIT     = 3'd3,
    SEND     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] key_q, key_d;
  logic [BW-1:0] din_q, din_d;
  logic [BW-1:0] res_q, res_d;
  logic          key_valid_q, key_valid_d;
  logic          start_q, start_d;
  logic          tx_valid_q, tx_valid_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    din_d       = din_q;
    res_d       = res_q;
    key_valid_d = key_valid_q;
    start_d     = 1'b0;
    tx_valid_d  = tx_valid_q;
    overrun_d   = overrun_q;
    case (state_q)
      KEY_LOAD: begin
        if (rx_valid) begin
          key_d = {key_q[KW-9:0], rx_data};
          if (cnt_q == KEY_LAST) begin
            cnt_d       = '0;
            key_valid_d = 1'b1;
            state_d     = BLK_LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      BLK_LOAD: begin
        if (rx_valid) begin
          din_d = {din_q[BW-9:0], rx_data};
          if (cnt_q == BLK_LAST) begin
            cnt_d   = '0;
            start_d = 1'b1;
            state_d = START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      START: begin
        overrun_d = overrun_q | rx_valid;
        state_d   = WAIT;
      end
      WAIT: begin
        overrun_d = overrun_q | rx_valid;
        if (aes_done) begin
          res_d      = aes_dout;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        overrun_d = overrun_q | rx_valid;
        if (tx_valid_q && tx_ready) begin
          res_d = res_q << 8;
          if (cnt_q == BLK_LAST) begin
            cnt_d      = '0;
            tx_valid_d = 1'b0;
            state_d    = BLK_LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = KEY_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= KEY_LOAD;
      cnt_q       <= '0;
      key_q       <= '0;
      din_q       <= '0;
      res_q       <= '0;
      key_valid_q <= 1'b0;
      start_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      din_q       <= din_d;
      res_q       <= res_d;
      key_valid_q <= key_valid_d;
      start_q     <= start_d;
      tx_valid_q  <= tx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // The TX byte is always the top of the result shift register.
  assign tx_data   = res_q[BW-1 -: 8];
  assign tx_valid  = tx_valid_q;
  assign aes_key   = key_q;
  assign key_valid = key_valid_q;
  assign aes_din   = din_q;
  assign aes_start = start_q;
  assign overrun   = overrun_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_aeses_uart_ctrl.sv
// tb_aeses_uart_ctrl: directed self-checking bench for aeses_uart_ctrl.
// Drives key/block bytes, models the AES core and drains TX.
module tb_aeses_uart_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [255:0] aes_key;
  logic         key_valid;
  logic [127:0] aes_din;
  logic         aes_start;
  logic [127:0] aes_dout;
  logic         aes_done;
  logic         overrun;
  logic [2:0]   state_o;

  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] BLK =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES =
    128'h8ea2b7ca516745bfeafc49904b496089;

  int total = 0;
  int bad = 0;
  int starts = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (aes_start) starts++;

  aeses_uart_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .aes_key(aes_key), .key_valid(key_valid),
    .aes_din(aes_din), .aes_start(aes_start),
    .aes_dout(aes_dout), .aes_done(aes_done),
    .overrun(overrun), .state_o(state_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] v);
    logic [127:0] t;
    t = v;
    for (int i = 0; i < 16; i++) begin
      send_byte(t[127:120]);
      t = t << 8;
    end
  endtask

  // Core model: a few cycles of latency, then a one-cycle done pulse.
  task automatic aes_respond;
    for (int i = 0; i < 3; i++) tick;
    chk("wait_state", 256'(state_o), 256'd3);
    aes_dout = RES;
    aes_done = 1'b1;
    tick;
    aes_done = 1'b0;
    aes_dout = '0;
    chk("send_state", 256'(state_o), 256'd4);
    chk("send_valid", 256'(tx_valid), 256'd1);
    chk("send_first", 256'(tx_data), 256'h8e);
  endtask

  // Drain n bytes with optionally random tx_ready, checking order and
  // that tx_data/tx_valid hold while stalled.
  task automatic drain(input int n, input bit rnd);
    logic [127:0] exp;
    logic [7:0]   held;
    bit           stall;
    int           got;
    int           cyc;
    exp = RES;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = 1'b0;
      if (tx_valid && tx_ready) begin
        chk("tx_byte", 256'(tx_data), 256'(exp[127:120]));
        exp = exp << 8;
        got++;
      end else if (tx_valid) begin
        held  = tx_data;
        stall = 1'b1;
      end
      tick;
      if (stall) begin
        chk("tx_hold_data", 256'(tx_data), 256'(held));
        chk("tx_hold_valid", 256'(tx_valid), 256'd1);
      end
      cyc++;
    end
    tx_ready = 1'b0;
    chk("tx_count", 256'(got), 256'(n));
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'haa;
    rx_valid = 1'b1;
    tx_ready = 1'b0;
    aes_dout = '0;
    aes_done = 1'b0;

    // T1 reset, with rx_valid active
    tick;
    tick;
    rst      = 1'b0;
    rx_valid = 1'b0;
    chk("rst_state", 256'(state_o), 256'd0);
    chk("rst_key", aes_key, 256'd0);
    chk("rst_kvalid", 256'(key_valid), 256'd0);
    chk("rst_din", 256'(aes_din), 256'd0);
    chk("rst_start", 256'(aes_start), 256'd0);
    chk("rst_txv", 256'(tx_valid), 256'd0);
    chk("rst_txd", 256'(tx_data), 256'd0);
    chk("rst_ovr", 256'(overrun), 256'd0);

    // T2 key load
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i));
      if (i == 30) chk("kvalid_early", 256'(key_valid), 256'd0);
    end
    chk("key_valid", 256'(key_valid), 256'd1);
    chk("key_value", aes_key, KEY);
    chk("key_state", 256'(state_o), 256'd1);

    // T3 block load and start pulse
    send_block(BLK);
    chk("din_value", 256'(aes_din), 256'(BLK));
    chk("start_pulse", 256'(aes_start), 256'd1);
    chk("start_state", 256'(state_o), 256'd2);
    tick;
    chk("start_low", 256'(aes_start), 256'd0);
    chk("start_count", 256'(starts), 256'd1);

    // T4 result with random back-pressure
    aes_respond();
    drain(16, 1'b1);
    tick;
    chk("post_txv", 256'(tx_valid), 256'd0);
    chk("post_state", 256'(state_o), 256'd1);

    // T5 five back-to-back blocks without re-keying
    for (int b = 0; b < 5; b++) begin
      send_block(BLK);
      tick;
      aes_respond();
      drain(16, b[0]);
      chk("rep_key", aes_key, KEY);
      chk("rep_starts", 256'(starts), 256'(b + 2));
    end
    chk("ovr_clean", 256'(overrun), 256'd0);

    // T6 overrun in WAIT, then reset mid-SEND
    send_block(BLK ^ 128'h1);
    tick;
    send_byte(8'h55);
    chk("ovr_set", 256'(overrun), 256'd1);
    chk("ovr_din", 256'(aes_din), 256'(BLK ^ 128'h1));
    chk("ovr_state", 256'(state_o), 256'd3);
    aes_respond();
    drain(8, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_txv", 256'(tx_valid), 256'd0);
    chk("mid_state", 256'(state_o), 256'd0);
    chk("mid_kvalid", 256'(key_valid), 256'd0);
    chk("mid_ovr", 256'(overrun), 256'd0);
    send_block(BLK);
    tick;
    chk("rekey_state", 256'(state_o), 256'd0);
    chk("rekey_nostart", 256'(starts), 256'd7);
    chk("rekey_key", aes_key, 256'(BLK));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
